// File: rtl/compare_sequencer_if.sv
// compare_sequencer_if
// Bundles the request, operand, cascade and result signals of the
// serial magnitude comparator.
//   master : requester side (drives start/operands/cascade, reads results)
//   slave  : comparator side
interface compare_sequencer_if #(
    parameter int BYTES = 4
);
    logic                   start;
    logic                   signed_mode;
    logic [8*BYTES-1:0]     a_ip;
    logic [8*BYTES-1:0]     b_ip;
    logic                   a_ip_G;
    logic                   b_ip_G;
    logic                   a_ip_E_b;
    logic                   busy;
    logic                   done;
    logic                   a_op_G;
    logic                   b_op_G;
    logic                   a_op_E_b;
    logic [3:0]             bytes_used;

    modport master (
        output start, signed_mode, a_ip, b_ip, a_ip_G, b_ip_G, a_ip_E_b,
        input  busy, done, a_op_G, b_op_G, a_op_E_b, bytes_used
    );

    modport slave (
        input  start, signed_mode, a_ip, b_ip, a_ip_G, b_ip_G, a_ip_E_b,
        output busy, done, a_op_G, b_op_G, a_op_E_b, bytes_used
    );
endinterface

// File: rtl/compare_sequencer.sv
// compare_sequencer
// Serial magnitude comparator: compares two BYTES-wide operands one 8-bit
// slice per cycle, most significant slice first, stopping at the first
// unequal slice. Fully equal operands resolve from the cascade inputs.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : compare_sequencer_if.slave (start/operands/cascade in,
//           busy/done/result flags/bytes_used out)
//
// state | meaning
// IDLE  | waiting for start
// CMP   | comparing slice idx_q, one slice per cycle
// FIN   | results valid (done high); start here chains the next compare
module compare_sequencer #(
    parameter int BYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    compare_sequencer_if.slave    bus
);
    localparam int IW = $clog2(BYTES);
    localparam logic [IW-1:0] IDX_MSB = IW'(BYTES - 1);

    typedef enum logic [1:0] {IDLE, CMP, FIN} state_t;

    state_t state_q, state_d;

    logic [8*BYTES-1:0] a_q, b_q;
    logic               sgn_q;
    logic               cas_ag_q, cas_bg_q;
    logic [IW-1:0]      idx_q;

    logic               a_g_q, b_g_q, a_e_q;
    logic [3:0]         bytes_used_q;

    logic [7:0]         a_sl, b_sl;
    logic               sl_eq, sl_gt;

    logic               load, dec, finish;
    logic               fin_ag, fin_bg, fin_e;
    logic [3:0]         fin_bytes;

    // Equality is the fall-through of the cascade priority, so the E input
    // adds no information beyond a_ip_G/b_ip_G.
    logic               cascade_eq_unused;
    assign cascade_eq_unused = bus.a_ip_E_b;

    assign a_sl  = a_q[8*idx_q +: 8];
    assign b_sl  = b_q[8*idx_q +: 8];
    assign sl_eq = (a_sl == b_sl);

    // Only the top slice carries the sign; lower slices are plain magnitude.
    always_comb begin
        sl_gt = (a_sl > b_sl);
        if (sgn_q && (idx_q == IDX_MSB)) begin
            sl_gt = ($signed(a_sl) > $signed(b_sl));
        end
    end

    assign fin_bytes = 4'(BYTES) - 4'(idx_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        dec     = 1'b0;
        finish  = 1'b0;
        fin_ag  = 1'b0;
        fin_bg  = 1'b0;
        fin_e   = 1'b1;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_d = CMP;
                end
            end
            CMP: begin
                if (!sl_eq) begin
                    finish  = 1'b1;
                    fin_ag  = sl_gt;
                    fin_bg  = ~sl_gt;
                    fin_e   = 1'b0;
                    state_d = FIN;
                end else if (idx_q != '0) begin
                    dec = 1'b1;
                end else begin
                    finish  = 1'b1;
                    fin_ag  = cas_ag_q;
                    fin_bg  = ~cas_ag_q & cas_bg_q;
                    fin_e   = ~cas_ag_q & ~cas_bg_q;
                    state_d = FIN;
                end
            end
            FIN: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_d = CMP;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q          <= '0;
            b_q          <= '0;
            sgn_q        <= 1'b0;
            cas_ag_q     <= 1'b0;
            cas_bg_q     <= 1'b0;
            idx_q        <= '0;
            a_g_q        <= 1'b0;
            b_g_q        <= 1'b0;
            a_e_q        <= 1'b1;
            bytes_used_q <= 4'd0;
        end else begin
            if (load) begin
                a_q      <= bus.a_ip;
                b_q      <= bus.b_ip;
                sgn_q    <= bus.signed_mode;
                cas_ag_q <= bus.a_ip_G;
                cas_bg_q <= bus.b_ip_G;
                idx_q    <= IDX_MSB;
            end else if (dec) begin
                idx_q <= idx_q - 1'b1;
            end
            if (finish) begin
                a_g_q        <= fin_ag;
                b_g_q        <= fin_bg;
                a_e_q        <= fin_e;
                bytes_used_q <= fin_bytes;
            end
        end
    end

    assign bus.busy       = (state_q == CMP);
    assign bus.done       = (state_q == FIN);
    assign bus.a_op_G     = a_g_q;
    assign bus.b_op_G     = b_g_q;
    assign bus.a_op_E_b   = a_e_q;
    assign bus.bytes_used = bytes_used_q;
endmodule

// File: tb/tb_compare_sequencer.sv
// tb_compare_sequencer
// Randomized and directed stimulus for compare_sequencer, checked against a
// whole-operand reference model (full-width compare plus leading-equal-byte
// count).
module tb_compare_sequencer;
    localparam int BYTES = 4;
    localparam int W     = 8 * BYTES;

    logic clk;
    logic rst_n;

    compare_sequencer_if #(.BYTES(BYTES)) bus ();

    compare_sequencer #(.BYTES(BYTES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [2:0] last_flags;
    logic [3:0] last_bytes;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference: unequal operands resolve by a full-width compare; the number
    // of slices examined is the count of leading equal bytes plus one.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic s, input logic ag, input logic bg,
                                  output logic [2:0] fl, output int k);
        logic gt;
        k = BYTES;
        for (int i = BYTES - 1; i >= 0; i--) begin
            if (a[8*i +: 8] != b[8*i +: 8]) begin
                k = BYTES - i;
                break;
            end
        end
        if (a == b) begin
            fl = ag ? 3'b100 : (bg ? 3'b010 : 3'b001);
        end else begin
            gt = s ? ($signed(a) > $signed(b)) : (a > b);
            fl = gt ? 3'b100 : 3'b010;
        end
    endfunction

    // Called at a negedge; issues one operation and returns at the negedge
    // where done is seen. glitch pulses start one cycle into the operation.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input logic ag, input logic bg,
                          input logic ae, input logic glitch);
        logic [2:0] efl;
        int k, cyc, bc;
        logic seen;
        model(a, b, s, ag, bg, efl, k);
        bus.start       = 1'b1;
        bus.a_ip        = a;
        bus.b_ip        = b;
        bus.signed_mode = s;
        bus.a_ip_G      = ag;
        bus.b_ip_G      = bg;
        bus.a_ip_E_b    = ae;
        @(posedge clk);
        cyc  = 0;
        bc   = 0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus.start = (cyc == 0) ? glitch : 1'b0;
            bus.a_ip        = $urandom;
            bus.b_ip        = $urandom;
            bus.signed_mode = 1'($urandom);
            bus.a_ip_G      = 1'($urandom);
            bus.b_ip_G      = 1'($urandom);
            bus.a_ip_E_b    = 1'($urandom);
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            if (bus.busy) bc++;
            @(posedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        chk("done_seen", 64'(seen), 64'd1);
        if (seen) begin
            chk("latency", 64'(cyc), 64'(k));
            chk("busy_cycles", 64'(bc), 64'(k));
            chk("flags", 64'({bus.a_op_G, bus.b_op_G, bus.a_op_E_b}), 64'(efl));
            chk("bytes_used", 64'(bus.bytes_used), 64'(k));
            chk("busy_at_done", 64'(bus.busy), 64'd0);
        end
        last_flags = efl;
        last_bytes = 4'(k);
    endtask

    // Idles n cycles after a result: no further done, results held.
    task automatic idle_gap(input int n);
        int extra;
        extra = 0;
        bus.start = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.done) extra++;
        end
        chk("no_extra_done", 64'(extra), 64'd0);
        chk("hold_flags", 64'({bus.a_op_G, bus.b_op_G, bus.a_op_E_b}), 64'(last_flags));
        chk("hold_bytes", 64'(bus.bytes_used), 64'(last_bytes));
    endtask

    task automatic rand_ops(output logic [W-1:0] a, output logic [W-1:0] b);
        int mode, p;
        a = $urandom;
        b = a;
        mode = $urandom_range(0, 4);
        if (mode == 0) begin
            b = $urandom;
        end else if (mode < 4) begin
            p = $urandom_range(0, BYTES - 1);
            b[8*p +: 8] = 8'($urandom);
        end
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        int extra;
        rst_n           = 1'b0;
        bus.start       = 1'b0;
        bus.signed_mode = 1'b0;
        bus.a_ip        = '0;
        bus.b_ip        = '0;
        bus.a_ip_G      = 1'b0;
        bus.b_ip_G      = 1'b0;
        bus.a_ip_E_b    = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_flags", 64'({bus.a_op_G, bus.b_op_G, bus.a_op_E_b}), 64'b001);
        chk("rst_bytes", 64'(bus.bytes_used), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Signed vs unsigned decision at the top slice
        run_op(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        idle_gap(2);
        run_op(32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle_gap(2);
        // Equal operands resolved by cascade
        run_op(32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle_gap(2);
        run_op(32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle_gap(2);
        run_op(32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        idle_gap(2);
        // Decision at the LSB slice with signed mode on
        run_op(32'h0000_0081, 32'h0000_0080, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle_gap(2);
        // start while busy ignored
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle_gap(10);
        // Back-to-back: second start taken in FIN
        run_op(32'h0500_0000, 32'h0500_0001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        run_op(32'h0100_0000, 32'h0200_0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle_gap(2);

        for (int i = 0; i < 300; i++) begin
            rand_ops(ra, rb);
            run_op(ra, rb, 1'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom), 1'($urandom));
            if ($urandom_range(0, 2) == 0) idle_gap($urandom_range(1, 3));
        end
        idle_gap(2);

        // Reset during CMP aborts without a done
        bus.start = 1'b1;
        bus.a_ip  = 32'hCAFE_F00D;
        bus.b_ip  = 32'hCAFE_F00D;
        bus.a_ip_G = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", 64'(bus.busy), 64'd0);
        chk("rst_mid_done", 64'(bus.done), 64'd0);
        chk("rst_mid_flags", 64'({bus.a_op_G, bus.b_op_G, bus.a_op_E_b}), 64'b001);
        chk("rst_mid_bytes", 64'(bus.bytes_used), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) extra++;
        end
        chk("rst_no_done", 64'(extra), 64'd0);
        // First start after release accepted immediately
        run_op(32'h7000_0000, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        idle_gap(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
